// File: rtl/line_buffer_col5_pkg.sv
// Shared median-filter package: image geometry defaults, window constants
// for the 3x3 and 5x5 filters, and the counter-width helper.
package line_buffer_col5_pkg;

  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int DATA_W_DEF = 8;

  // 3x3 median filter window
  localparam int WIN3_SIZE = 3;
  localparam int WIN3_TAPS = WIN3_SIZE * WIN3_SIZE;
  localparam int WIN3_MID  = WIN3_TAPS / 2;

  // 5x5 median filter window
  localparam int WIN5_SIZE = 5;
  localparam int WIN5_TAPS = WIN5_SIZE * WIN5_SIZE;
  localparam int WIN5_MID  = WIN5_TAPS / 2;

  // Number of rows that must be buffered before a 5-tall column is complete
  localparam int WIN5_FILL_ROWS = WIN5_SIZE - 1;

  // Width of a counter that spans 0..n-1 (never narrower than one bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buffer_col5_line_delay.sv
// One image row of enable-gated delay. The read is asynchronous at the write
// pointer, so dout always shows the value written DEPTH accepted samples ago
// and is overwritten by din on the next enabled edge.
module line_delay
  import line_buffer_col5_pkg::*;
#(
  parameter int DEPTH  = IMG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int            PW   = cnt_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;

  assign dout = mem[ptr];

  // Circular read/write pointer; reset realigns all four lines together
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

  // Row storage: no reset, stale entries are masked by the row counter upstream
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/line_buffer_col5.sv
// Five-row column extractor for a 5x5 median filter. Four chained row delays
// present rows r-4..r of the current column; a registered column is emitted
// for every accepted pixel once four full rows of the frame are buffered.
module line_buffer_col5
  import line_buffer_col5_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [DATA_W-1:0]       S1,
  output logic [DATA_W-1:0]       S2,
  output logic [DATA_W-1:0]       S3,
  output logic [DATA_W-1:0]       S4,
  output logic [DATA_W-1:0]       S5,
  output logic                    done_o,
  output logic [cnt_w(IMG_W)-1:0] col_o,
  output logic                    frame_end_o
);

  localparam int            CW        = cnt_w(IMG_W);
  localparam int            RW        = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(WIN5_FILL_ROWS);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              accept;
  logic              col_valid;
  logic [DATA_W-1:0] tap [WIN5_SIZE];

  // A pixel presented during reset is dropped, so the lines must not move
  assign accept    = done_i && !rst;
  assign col_valid = (row >= ROW_FIRST);
  assign tap[0]    = data_i;

  // tap[k] is the pixel accepted k rows earlier at the same column
  for (genvar k = 1; k < WIN5_SIZE; k++) begin : g_line
    line_delay #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_line (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (tap[k-1]),
      .dout (tap[k])
    );
  end

  // Raster position of the pixel being accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (done_i) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Registered column output; data only refreshes when the column is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      done_o      <= 1'b0;
      frame_end_o <= 1'b0;
      col_o       <= '0;
      S1          <= '0;
      S2          <= '0;
      S3          <= '0;
      S4          <= '0;
      S5          <= '0;
    end else if (done_i) begin
      done_o      <= col_valid;
      frame_end_o <= (row == ROW_LAST) && (col == COL_LAST);
      if (col_valid) begin
        col_o <= col;
        S1    <= tap[4];
        S2    <= tap[3];
        S3    <= tap[2];
        S4    <= tap[1];
        S5    <= tap[0];
      end
    end else begin
      done_o      <= 1'b0;
      frame_end_o <= 1'b0;
    end
  end

endmodule
